// File: rtl/uart_cfg_sequencer_pkg.sv
// Shared constants for the UART configuration sequencer: 16550 register map,
// error codes and the sequencer state encoding.
package uart_cfg_pkg;

   localparam logic [2:0] ADR_RBR_THR_DLL = 3'd0;
   localparam logic [2:0] ADR_IER_DLM     = 3'd1;
   localparam logic [2:0] ADR_FCR         = 3'd2;
   localparam logic [2:0] ADR_LCR         = 3'd3;
   localparam logic [2:0] ADR_MCR         = 3'd4;

   localparam int         LCR_DLAB        = 7;
   localparam int         NUM_STEPS       = 8;
   localparam logic [3:0] ERR_DIV_ZERO    = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      GAP,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/uart_cfg_sequencer_ack_timer.sv
// Ack watchdog: counts strobe cycles without ack; expired is high during the
// last allowed cycle so the caller can abort on that edge (an ack in it still wins).
module wb_ack_timer #(
   parameter int ACK_TIMEOUT = 16,
   parameter int TO_W        = $clog2(ACK_TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == TO_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/uart_cfg_sequencer.sv
// Wishbone master that programs a 16550 in eight fixed steps; one cycle per ack plus
// one idle gap per step, done at start+1+8(L+1); stalls on the slave ack with a timeout.
module uart_cfg_sequencer
   import uart_cfg_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int TO_W        = $clog2(ACK_TIMEOUT + 1)
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic [15:0] divisor_i,
   input  logic [6:0]  lcr_cfg_i,
   input  logic [7:0]  fcr_i,
   input  logic [3:0]  ier_i,
   input  logic [4:0]  mcr_i,
   output logic [2:0]  wb_adr_o,
   output logic [7:0]  wb_dat_o,
   input  logic [7:0]  wb_dat_i,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [3:0]  err_step_o
);

   state_t      state;
   logic [2:0]  step;
   logic [15:0] div_q;
   logic [6:0]  lcr_q;
   logic [7:0]  fcr_q;
   logic [3:0]  ier_q;
   logic [4:0]  mcr_q;

   logic        timeout, rd_ok, from_gap;
   logic [2:0]  nxt_step, nxt_adr;
   logic [7:0]  nxt_dat;
   logic        nxt_we;
   logic [15:0] src_div;
   logic [6:0]  src_lcr;
   logic [7:0]  src_fcr;
   logic [3:0]  src_ier;
   logic [4:0]  src_mcr;

   wb_ack_timer #(
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .TO_W       (TO_W)
   ) u_timer (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clr    (state != REQ),
      .en     (state == REQ && !wb_ack_i),
      .expired(timeout)
   );

   assign from_gap = (state == GAP);
   assign rd_ok    = (wb_dat_i == {1'b0, lcr_q});
   assign wb_cyc_o = wb_stb_o;

   // Step 0 launches straight from the inputs, which are latched on the same edge.
   always_comb begin
      nxt_step = from_gap ? step + 3'd1 : 3'd0;
      src_div  = from_gap ? div_q : divisor_i;
      src_lcr  = from_gap ? lcr_q : lcr_cfg_i;
      src_fcr  = from_gap ? fcr_q : fcr_i;
      src_ier  = from_gap ? ier_q : ier_i;
      src_mcr  = from_gap ? mcr_q : mcr_i;
      nxt_adr  = ADR_LCR;
      nxt_dat  = 8'h00;
      nxt_we   = 1'b1;
      case (nxt_step)
         3'd0: begin
            nxt_dat           = {1'b0, src_lcr};
            nxt_dat[LCR_DLAB] = 1'b1;
         end
         3'd1: begin nxt_adr = ADR_RBR_THR_DLL; nxt_dat = src_div[7:0];      end
         3'd2: begin nxt_adr = ADR_IER_DLM;     nxt_dat = src_div[15:8];     end
         3'd3: begin                            nxt_dat = {1'b0, src_lcr};   end
         3'd4: begin nxt_adr = ADR_FCR;         nxt_dat = src_fcr;           end
         3'd5: begin nxt_adr = ADR_IER_DLM;     nxt_dat = {4'h0, src_ier};   end
         3'd6: begin nxt_adr = ADR_MCR;         nxt_dat = {3'h0, src_mcr};   end
         default: nxt_we = 1'b0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         step       <= 3'd0;
         div_q      <= '0;
         lcr_q      <= '0;
         fcr_q      <= '0;
         ier_q      <= '0;
         mcr_q      <= '0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_we_o    <= 1'b0;
         wb_stb_o   <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         error_o    <= 1'b0;
         err_step_o <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  div_q      <= divisor_i;
                  lcr_q      <= lcr_cfg_i;
                  fcr_q      <= fcr_i;
                  ier_q      <= ier_i;
                  mcr_q      <= mcr_i;
                  step       <= 3'd0;
                  done_o     <= 1'b0;
                  if (divisor_i == 16'h0000) begin
                     state      <= ERR;
                     error_o    <= 1'b1;
                     err_step_o <= ERR_DIV_ZERO;
                  end else begin
                     state      <= REQ;
                     busy_o     <= 1'b1;
                     error_o    <= 1'b0;
                     err_step_o <= '0;
                     wb_stb_o   <= 1'b1;
                     wb_adr_o   <= nxt_adr;
                     wb_dat_o   <= nxt_dat;
                     wb_we_o    <= nxt_we;
                  end
               end
            end
            REQ: begin
               if ((wb_ack_i && step == 3'(NUM_STEPS - 1) && !rd_ok) || (!wb_ack_i && timeout)) begin
                  state      <= ERR;
                  busy_o     <= 1'b0;
                  error_o    <= 1'b1;
                  err_step_o <= {1'b0, step};
                  wb_stb_o   <= 1'b0;
                  wb_adr_o   <= '0;
                  wb_dat_o   <= '0;
                  wb_we_o    <= 1'b0;
               end else if (wb_ack_i) begin
                  state    <= GAP;
                  wb_stb_o <= 1'b0;
               end
            end
            GAP: begin
               if (step == 3'(NUM_STEPS - 1)) begin
                  state    <= DONE;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
                  wb_adr_o <= '0;
                  wb_dat_o <= '0;
                  wb_we_o  <= 1'b0;
               end else begin
                  state    <= REQ;
                  step     <= nxt_step;
                  wb_stb_o <= 1'b1;
                  wb_adr_o <= nxt_adr;
                  wb_dat_o <= nxt_dat;
                  wb_we_o  <= nxt_we;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Self-checking bench: directed plus randomized configuration runs against a
// transaction-level model of the eight-step register programming sequence.
module tb_uart_cfg_sequencer;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] divisor = '0;
   logic [6:0]  lcr = '0;
   logic [7:0]  fcr = '0;
   logic [3:0]  ier = '0;
   logic [4:0]  mcr = '0;
   logic [2:0]  adr;
   logic [7:0]  dat_o;
   logic [7:0]  dat_i = '0;
   logic        we, stb, cyc, busy, done, error;
   logic        ack = 1'b0;
   logic [3:0]  err_step;
   logic [20:0] outs;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_cfg_sequencer #(.ACK_TIMEOUT(TMO)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .start_i   (start),
      .divisor_i (divisor),
      .lcr_cfg_i (lcr),
      .fcr_i     (fcr),
      .ier_i     (ier),
      .mcr_i     (mcr),
      .wb_adr_o  (adr),
      .wb_dat_o  (dat_o),
      .wb_dat_i  (dat_i),
      .wb_we_o   (we),
      .wb_stb_o  (stb),
      .wb_cyc_o  (cyc),
      .wb_ack_i  (ack),
      .busy_o    (busy),
      .done_o    (done),
      .error_o   (error),
      .err_step_o(err_step)
   );

   assign outs = {adr, dat_o, we, stb, cyc, busy, done, error, err_step};

   // Slave model: acks in the lat-th strobe cycle, never acks transfer number noack.
   int          lat = 1, noack = -1, hi = 0, low = 0;
   int          unstable = 0, bad_gap = 0, stb_cnt = 0, cyc_bad = 0;
   logic [7:0]  rdata = '0;
   logic [11:0] prev = '0;
   logic [11:0] got_q[$];
   logic [11:0] exp_q[$];

   always @(negedge clk) begin
      if (cyc !== stb) cyc_bad++;
      if (stb) begin
         if (hi > 0 && {we, adr, dat_o} !== prev) unstable++;
         prev = {we, adr, dat_o};
         hi++;
         stb_cnt++;
         if (busy) begin
            if (low > 1) bad_gap++;
            low = 0;
         end
         if (got_q.size() != noack && hi == lat) begin
            ack   = 1'b1;
            dat_i = we ? 8'h00 : rdata;
            got_q.push_back(prev);
         end else begin
            ack = 1'b0;
         end
      end else begin
         ack = 1'b0;
         hi  = 0;
         if (busy) low++;
         else low = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   function automatic void build_exp(input logic [15:0] d, input logic [6:0] l,
                                     input logic [7:0] f, input logic [3:0] ie,
                                     input logic [4:0] m);
      logic [2:0] a[8];
      logic [7:0] v[8];
      a = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd4, 3'd3};
      v = '{{1'b1, l}, d[7:0], d[15:8], {1'b0, l}, f, {4'h0, ie}, {3'h0, m}, 8'h00};
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back({(i != 7), a[i], v[i]});
   endfunction

   task automatic run(input logic [15:0] d, input logic [6:0] l, input logic [7:0] f,
                      input logic [3:0] ie, input logic [4:0] m, input int lt,
                      input int na, input logic [7:0] rd, input bit disturb);
      int         k, fstep, exp_end, exp_stb, exp_n;
      bit         exp_ok;
      logic [3:0] exp_es;
      @(negedge clk);
      divisor = d; lcr = l; fcr = f; ier = ie; mcr = m;
      lat = lt; noack = na; rdata = rd;
      got_q.delete();
      unstable = 0; bad_gap = 0; stb_cnt = 0; cyc_bad = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 1;
      while (busy && k < 2000) begin
         if (disturb && k == 3) begin
            start   = 1'b1;
            divisor = 16'($urandom);
            lcr     = 7'($urandom);
            fcr     = 8'($urandom);
            ier     = 4'($urandom);
            mcr     = 5'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;

      build_exp(d, l, f, ie, m);
      fstep  = (lt > TMO) ? 0 : na;
      exp_ok = 1'b0;
      exp_es = 4'h0;
      if (d == 16'h0000) begin
         exp_es = 4'hF; exp_n = 0; exp_stb = 0; exp_end = 1;
      end else if (fstep >= 0 && fstep < 8) begin
         exp_es = 4'(fstep); exp_n = fstep; exp_stb = fstep * lt + TMO;
         exp_end = 1 + fstep * (lt + 1) + TMO;
      end else if (rd != {1'b0, l}) begin
         exp_es = 4'h7; exp_n = 8; exp_stb = 8 * lt; exp_end = 1 + 7 * (lt + 1) + lt;
      end else begin
         exp_ok = 1'b1; exp_n = 8; exp_stb = 8 * lt; exp_end = 1 + 8 * (lt + 1);
      end

      chk("end_cycle", k, exp_end);
      chk("busy_end", busy, 0);
      chk("stb_end", stb, 0);
      chk("done", done, exp_ok);
      chk("error", error, !exp_ok);
      chk("err_step", err_step, exp_ok ? 4'h0 : exp_es);
      chk("stb_cycles", stb_cnt, exp_stb);
      chk("txn_count", got_q.size(), exp_n);
      for (int i = 0; i < exp_n && i < got_q.size(); i++) chk("txn", got_q[i], exp_q[i]);
      chk("stb_stable", unstable, 0);
      chk("gap_len", bad_gap, 0);
      chk("cyc_eq_stb", cyc_bad, 0);
   endtask

   logic [15:0] r_d;
   logic [6:0]  r_l;
   logic [7:0]  r_rd;
   int          r_na, k;

   initial begin
      // reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; divisor = 16'h0010;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs, 0);
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", outs, 0);

      run(16'h001B, 7'h03, 8'hC7, 4'h1, 5'h03, 1, -1, 8'h03, 0);
      run(16'h001B, 7'h03, 8'hC7, 4'h1, 5'h03, 3, -1, 8'h03, 0);
      run(16'h001B, 7'h03, 8'hC7, 4'h1, 5'h03, 1, 2, 8'h03, 0);
      run(16'h001B, 7'h03, 8'hC7, 4'h1, 5'h03, 1, -1, 8'h03, 0);
      run(16'h001B, 7'h03, 8'hC7, 4'h1, 5'h03, 2, -1, 8'h83, 0);
      run(16'h0000, 7'h03, 8'hC7, 4'h1, 5'h03, 1, -1, 8'h03, 0);
      run(16'hA55A, 7'h1F, 8'h07, 4'hF, 5'h1F, 2, -1, 8'h1F, 1);
      run(16'h0102, 7'h2B, 8'h81, 4'h5, 5'h0A, TMO, -1, 8'h2B, 0);
      run(16'h0102, 7'h2B, 8'h81, 4'h5, 5'h0A, TMO + 1, -1, 8'h2B, 0);

      // reset while step 4 is on the bus
      @(negedge clk);
      divisor = 16'h0033; lcr = 7'h07; fcr = 8'h01; ier = 4'h3; mcr = 5'h01;
      lat = 10; noack = -1; rdata = 8'h07;
      got_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (!(got_q.size() == 4 && stb) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_step4", {got_q.size() == 4, stb}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrun_reset", outs, 0);
      @(negedge clk);
      rst = 1'b0;
      run(16'h0033, 7'h07, 8'h01, 4'h3, 5'h01, 1, -1, 8'h07, 0);

      for (int n = 0; n < 20; n++) begin
         r_d  = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
         r_l  = 7'($urandom);
         r_na = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
         r_rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {1'b0, r_l};
         run(r_d, r_l, 8'($urandom), 4'($urandom), 5'($urandom),
             int'($urandom_range(1, 4)), r_na, r_rd, bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cfg_sequencer.md
Name: uart_cfg_sequencer

Overview:
Wishbone master that programs the uart_16550 register file after reset, or on request, from a set of configuration inputs. It runs a fixed eight-step sequence:
- divisor latch access, then DLL and DLM
- line format (LCR)
- FCR, IER, MCR
- an LCR read-back check.

It sits between the top-level configuration straps and the 8-bit Wishbone slave port of uart_16550. It owns that port only while busy_o is high. It reports done or error, with the failing step.

Parameters:
ACK_TIMEOUT, 16, number of stb-high cycles without ack before the transaction aborts (legal range 2..255).
TO_W, $clog2(ACK_TIMEOUT+1), width of the timeout counter.

Ports:
wb_clk_i  input  1  clock; all logic is on the rising edge.
wb_rst_i  input  1  reset, synchronous, active-high.
start_i  input  1  one-cycle request to run the sequence; ignored while busy_o=1.
divisor_i  input  16  baud divisor; {DLM,DLL}.
lcr_cfg_i  input  7  LCR[6:0]: word length, stop bits, parity, break.
fcr_i  input  8  value written to FCR.
ier_i  input  4  IER[3:0]; IER[7:4] is written as 0.
mcr_i  input  5  MCR[4:0]; MCR[7:5] is written as 0.
wb_adr_o  output  3  register address.
wb_dat_o  output  8  write data.
wb_dat_i  input  8  read data.
wb_we_o  output  1  1 = write.
wb_stb_o  output  1  strobe.
wb_cyc_o  output  1  cycle; always equal to wb_stb_o.
wb_ack_i  input  1  slave acknowledge.
busy_o  output  1  sequence in progress.
done_o  output  1  sequence completed OK; held until the next accepted start or reset.
error_o  output  1  sequence aborted; held until the next accepted start or reset.
err_step_o  output  4  failing step 0..7, or 4'hF for divisor zero; 0 when error_o=0.

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE and the step counter to 0. Reset asserted mid-transaction drops stb/cyc on the next edge, with no completion.
- Accepted start, sampled at edge N:
  - All config inputs latch into shadow registers; later input changes have no effect on the running sequence.
  - done_o and error_o clear, busy_o=1.
  - wb_stb_o rises at cycle N+1.
- Divisor zero: if divisor_i==0 at start, no bus cycle is issued. At N+1: error_o=1, err_step_o=4'hF, busy_o=0.
- Steps (address, data):
  - 0: 3, {1,lcr} (write)
  - 1: 0, div[7:0] (write)
  - 2: 1, div[15:8] (write)
  - 3: 3, {0,lcr} (write)
  - 4: 2, fcr (write)
  - 5: 1, {0000,ier} (write)
  - 6: 4, {000,mcr} (write)
  - 7: 3, read; expect {0,lcr}
- FSM states: IDLE -> REQ -> GAP -> REQ ... -> DONE, or ERR.
  - REQ: stb/cyc/adr/dat/we are held stable until ack is sampled high.
  - Ack sampled at edge: the next cycle is GAP, with stb=0 for exactly one cycle, then the step increments.
  - Ack latency L cycles (L>=1) gives L+1 cycles per step. done_o=1 and busy_o=0 on the cycle after GAP of step 7, i.e. start + 1 + 8(L+1).
  - Step 7 data is captured on the ack edge. A mismatch goes to ERR with err_step_o=7.
- Timeout:
  - The counter clears on entering REQ and increments each REQ cycle without ack.
  - When it reaches ACK_TIMEOUT, stb/cyc drop on the next edge, error_o=1, err_step_o=current step, busy_o=0.
  - An ack arriving in the same cycle the count reaches ACK_TIMEOUT counts as success; ack wins.
- Ack while stb=0 is ignored.
- start_i together with wb_rst_i: reset wins.
- wb_we_o is 0 only in step 7. wb_dat_o is 0 during the read and in IDLE.

Decomposition:
- Package uart_cfg_pkg holds:
  - register address localparams: ADR_RBR_THR_DLL=0, ADR_IER_DLM=1, ADR_FCR=2, ADR_LCR=3, ADR_MCR=4
  - LCR_DLAB bit index 7
  - NUM_STEPS=8 and ERR_DIV_ZERO=4'hF
  - FSM state enum {IDLE, REQ, GAP, DONE, ERR}
- One sub-module, wb_ack_timer: clear/enable/expired wrapping the TO_W counter. The step decode stays a combinational case in the top module.

Test Plan:
- Divisor 16'h001B, lcr 7'h03, fcr 8'hC7, ier 4'h1, mcr 5'h03; slave L=1 returning 8'h03:
  - writes go out in order (3,83), (0,1B), (1,00), (3,03), (2,C7), (1,01), (4,03), then read of address 3
  - done_o=1 exactly 17 cycles after the start edge; error_o=0.
- Same config with slave L=3 -> 33 cycles to done_o; stb stable throughout REQ; exactly one stb-low cycle between steps.
- Slave never acks step 2 -> stb drops 16 REQ cycles after it rose; error_o=1, err_step_o=2, busy_o=0. Next start runs cleanly.
- Read-back returns 8'h83 -> error_o=1, err_step_o=7, done_o=0.
- divisor_i=0 -> no stb, ever; next cycle error_o=1, err_step_o=4'hF.
- Reset at step 4 mid-REQ -> next edge all outputs 0. start_i pulsed while busy, and input changes after start, have no effect on the bus sequence.
